pc_fetch_seq: RTL and testbench
===============================

Name: pc_fetch_seq

Overview:
- Program-counter sequencer and instruction-fetch requester. It sits on the consuming side of the branch-target adder.
- Takes the computed branch target, a jump target and a flush redirect, and holds the architectural PC.
- Issues one instruction-memory read at a time over a req/ack handshake and presents each fetched instruction to decode with a valid/stall handshake.

Parameters:
- ADDR_W, 32, width of PC and all target/address buses.
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- branch_target  in  ADDR_W  branch target (PC+4 + shifted offset) from the branch adder.
- branch_taken  in  1  take branch_target on instruction accept.
- jump_target  in  ADDR_W  jump destination.
- jump_en  in  1  take jump_target on instruction accept.
- flush  in  1  exception/redirect; sampled every cycle.
- flush_pc  in  ADDR_W  redirect address for flush.
- stall  in  1  decode cannot accept the presented instruction.
- imem_req  out  1  instruction-memory read request.
- imem_addr  out  ADDR_W  read address, word-aligned.
- imem_ack  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  32  instruction word.
- instr_valid  out  1  instr/pc_out hold a valid instruction.
- instr  out  32  fetched instruction.
- pc_out  out  ADDR_W  address of instr.
- pc_plus4  out  ADDR_W  pc_out + 4, fed to the branch adder.
- misalign_err  out  1  one-cycle pulse: a selected target had bits [1:0] nonzero.

Behaviour:
- Reset (rst_n low, asynchronous): state=S_BOOT, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, pc_out=RESET_PC, pc_plus4=RESET_PC+4, misalign_err=0, drop flag=0. Reset mid-transaction abandons it; any later imem_ack is ignored until imem_req rises again.
- States:
  - S_BOOT: imem_req=0; next cycle goes to S_REQ. Entered after reset or after a dropped fetch.
  - S_REQ: imem_req=1, imem_addr=pc. Address must be held stable until imem_ack. imem_ack may arrive in the same cycle req rises (zero-wait).
    - On ack with drop=0 and flush=0: instr<=imem_rdata, pc_out<=pc, go to S_VALID.
    - On ack with drop=1 or flush=1: discard data, pc<=stored/ current flush_pc, drop<=0, go to S_BOOT.
  - S_VALID: instr_valid=1; instr and pc_out held stable while stall=1.
    - If !stall: pc<=next_pc, go to S_REQ.
    - If flush (regardless of stall): pc<=flush_pc, instr_valid=0 next cycle, go to S_REQ.
- Flush in S_REQ without ack: drop<=1 and latch flush_pc; the request stays asserted with the old address until ack. A later flush overwrites the latched pc.
- imem_ack while imem_req=0 is ignored.
- next_pc priority: flush > jump_en > branch_taken > pc+4. Redirects are sampled only on the accept cycle (S_VALID & !stall).
- Alignment: a selected target with [1:0]!=0 is used as {target[ADDR_W-1:2],2'b00} and misalign_err pulses the following cycle.
- Arithmetic: pc+4 is modulo 2^ADDR_W. 0xFFFF_FFFC wraps to 0x0000_0000 with no error.
- Latency: first imem_req is 1 cycle after rst_n deasserts. With zero-wait memory, instr_valid appears the cycle after ack. Peak throughput is one instruction per 2 cycles.

Decomposition:
- Package pc_seq_pkg:
  - state enum: S_BOOT, S_REQ, S_VALID.
  - INSTR_BYTES=4.
  - ALIGN_MASK.
  - default RESET_PC constant.
- Sub-module next_pc_sel (combinational): priority mux, pc+4, alignment force, misalign flag. Instantiated once.

Test Plan:
- Reset release with zero-wait memory, stall=0 -> imem_addr sequence 0x0, 0x4, 0x8; instr_valid every other cycle; pc_plus4 = pc_out+4.
- Accept instr at 0x10 with branch_taken=1, branch_target=0x40 -> next imem_addr=0x40; same with jump_en=1, jump_target=0x80 -> 0x80 (jump wins).
- stall=1 for 3 cycles at pc_out=0x8 -> instr/pc_out unchanged, no imem_req; stall=0 -> req at 0xC.
- Flush (flush_pc=0x200) while S_REQ waiting 4 cycles for ack -> req held at old addr; returned data not presented; after 1 idle cycle req at 0x200.
- branch_target=0x43 taken -> imem_addr=0x40, misalign_err one-cycle pulse; pc=0xFFFF_FFFC sequential -> next addr 0x0000_0000.
- rst_n low mid-request -> all outputs at reset values immediately; stray imem_ack ignored; restart at RESET_PC.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer / instruction-fetch requester.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2
    } pc_state_e;

    localparam int          INSTR_BYTES      = 4;
    localparam logic [1:0]  ALIGN_MASK       = 2'b11;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return (low_bits & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_seq_next_pc_sel.sv
// Next-PC priority mux (flush > jump > branch > pc+4) with word-alignment forcing.
module next_pc_sel
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] next_pc,
    output logic              misalign
);

    logic [ADDR_W-1:0] raw_pc;
    logic              is_target;

    always_comb begin
        raw_pc    = pc + ADDR_W'(INSTR_BYTES);
        is_target = 1'b1;
        if (flush) begin
            raw_pc = flush_pc;
        end else if (jump_en) begin
            raw_pc = jump_target;
        end else if (branch_taken) begin
            raw_pc = branch_target;
        end else begin
            is_target = 1'b0;
        end
        // Sequential pc+4 wraps modulo 2^ADDR_W and is never flagged.
        next_pc  = {raw_pc[ADDR_W-1:2], 2'b00};
        misalign = is_target && is_misaligned(raw_pc[1:0]);
    end

endmodule

// File: rtl/pc_fetch_seq.sv
// Architectural PC holder issuing one imem read at a time and presenting instructions to decode.
module pc_fetch_seq
    import pc_seq_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              jump_en,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic              stall,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              misalign_err,
    output pc_state_e         fsm_state
);

    // Handshakes: imem_req stays high with imem_addr stable until imem_ack (same-cycle
    // ack allowed); ack without req is ignored. Decode accepts when instr_valid && !stall.

    pc_state_e         state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [31:0]       instr_n;
    logic [ADDR_W-1:0] pc_out_n;
    logic              drop, drop_n;
    logic [ADDR_W-1:0] drop_pc, drop_pc_n;
    logic              misalign_n;
    logic [ADDR_W-1:0] sel_pc;
    logic              sel_misalign;

    next_pc_sel #(.ADDR_W(ADDR_W)) u_next_pc_sel (
        .pc            (pc),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .jump_en       (jump_en),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .next_pc       (sel_pc),
        .misalign      (sel_misalign)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_BOOT;
            pc           <= RESET_PC;
            instr        <= 32'h0;
            pc_out       <= RESET_PC;
            drop         <= 1'b0;
            drop_pc      <= RESET_PC;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_n;
            pc           <= pc_n;
            instr        <= instr_n;
            pc_out       <= pc_out_n;
            drop         <= drop_n;
            drop_pc      <= drop_pc_n;
            misalign_err <= misalign_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        instr_n    = instr;
        pc_out_n   = pc_out;
        drop_n     = drop;
        drop_pc_n  = drop_pc;
        misalign_n = 1'b0;
        case (state)
            S_BOOT: begin
                state_n = S_REQ;
            end
            S_REQ: begin
                misalign_n = flush && sel_misalign;
                if (imem_ack) begin
                    if (flush || drop) begin
                        // Returned data belongs to an abandoned stream; refetch from the redirect.
                        pc_n    = flush ? sel_pc : drop_pc;
                        drop_n  = 1'b0;
                        state_n = S_BOOT;
                    end else begin
                        instr_n  = imem_rdata;
                        pc_out_n = pc;
                        state_n  = S_VALID;
                    end
                end else if (flush) begin
                    drop_n    = 1'b1;
                    drop_pc_n = sel_pc;
                end
            end
            S_VALID: begin
                if (flush || !stall) begin
                    pc_n       = sel_pc;
                    misalign_n = sel_misalign;
                    state_n    = S_REQ;
                end
            end
            default: begin
                state_n = S_BOOT;
            end
        endcase
    end

    assign imem_req    = (state == S_REQ);
    assign imem_addr   = pc;
    assign instr_valid = (state == S_VALID);
    assign pc_plus4    = pc_out + ADDR_W'(INSTR_BYTES);
    assign fsm_state   = state;

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Directed bench for pc_fetch_seq: sequencing, stall, redirects, flush drop, wrap, reset.
module tb_pc_fetch_seq;
    import pc_seq_pkg::*;

    localparam logic [31:0] MEM_KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] branch_target, jump_target, flush_pc;
    logic        branch_taken, jump_en, flush, stall;
    logic        imem_req, imem_ack, instr_valid, misalign_err;
    logic [31:0] imem_addr, imem_rdata, instr, pc_out, pc_plus4;
    pc_state_e   fsm_state;

    int n_cmp = 0;
    int n_err = 0;
    logic mem_auto = 1'b1;

    pc_fetch_seq #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .branch_target (branch_target),
        .branch_taken  (branch_taken),
        .jump_target   (jump_target),
        .jump_en       (jump_en),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .stall         (stall),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .pc_out        (pc_out),
        .pc_plus4      (pc_plus4),
        .misalign_err  (misalign_err),
        .fsm_state     (fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance to the next falling edge; a zero-wait memory answers any pending request.
    task automatic step();
        @(negedge clk);
        if (mem_auto) begin
            imem_ack   = imem_req;
            imem_rdata = imem_req ? (imem_addr ^ MEM_KEY) : 32'h0;
        end
    endtask

    // Observation vector {req, valid, addr}
    function automatic logic [33:0] obs();
        return {imem_req, instr_valid, imem_addr};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; branch_taken = 0; jump_en = 0; flush = 0; stall = 0;
        branch_target = 0; jump_target = 0; flush_pc = 0; imem_ack = 0; imem_rdata = 0;
        step();
        n_cmp++; if (obs() !== {1'b0, 1'b0, 32'h0}) begin n_err++; $display("FAIL reset_obs: got %h want %h", obs(), {1'b0, 1'b0, 32'h0}); end
        n_cmp++; if (instr !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h want 0", instr); end
        n_cmp++; if (pc_out !== 32'h0) begin n_err++; $display("FAIL reset_pc_out: got %h want 0", pc_out); end
        n_cmp++; if (pc_plus4 !== 32'h4) begin n_err++; $display("FAIL reset_pc_plus4: got %h want 4", pc_plus4); end
        n_cmp++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL reset_misalign: got %b want 0", misalign_err); end
        n_cmp++; if (fsm_state !== S_BOOT) begin n_err++; $display("FAIL reset_state: got %0d want %0d", fsm_state, S_BOOT); end
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (obs() !== {1'b1, 1'b0, 32'(i * 4)}) begin n_err++; $display("FAIL seq_req%0d: got %h want %h", i, obs(), {1'b1, 1'b0, 32'(i * 4)}); end
            if (i == 2) break;
            step();
            n_cmp++; if ({imem_req, instr_valid, pc_out} !== {1'b0, 1'b1, 32'(i * 4)}) begin n_err++; $display("FAIL seq_valid%0d: got %h want %h", i, {imem_req, instr_valid, pc_out}, {1'b0, 1'b1, 32'(i * 4)}); end
            n_cmp++; if (instr !== (32'(i * 4) ^ MEM_KEY)) begin n_err++; $display("FAIL seq_instr%0d: got %h want %h", i, instr, 32'(i * 4) ^ MEM_KEY); end
            n_cmp++; if (pc_plus4 !== 32'(i * 4 + 4)) begin n_err++; $display("FAIL seq_pc_plus4_%0d: got %h want %h", i, pc_plus4, 32'(i * 4 + 4)); end
        end
    endtask

    task automatic test_stall();
        step();
        n_cmp++; if ({instr_valid, pc_out} !== {1'b1, 32'h8}) begin n_err++; $display("FAIL stall_enter: got %h want %h", {instr_valid, pc_out}, {1'b1, 32'h8}); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if ({imem_req, instr_valid, pc_out, instr} !== {1'b0, 1'b1, 32'h8, 32'h8 ^ MEM_KEY}) begin
                n_err++; $display("FAIL stall_hold%0d: got req=%b valid=%b pc_out=%h instr=%h want req=0 valid=1 pc_out=8 instr=%h", i, imem_req, instr_valid, pc_out, instr, 32'h8 ^ MEM_KEY);
            end
        end
        stall = 1'b0;
        step();
        n_cmp++; if (obs() !== {1'b1, 1'b0, 32'hC}) begin n_err++; $display("FAIL stall_release: got %h want %h", obs(), {1'b1, 1'b0, 32'hC}); end
        step();
        step();
        n_cmp++; if (obs() !== {1'b1, 1'b0, 32'h10}) begin n_err++; $display("FAIL seq_0x10: got %h want %h", obs(), {1'b1, 1'b0, 32'h10}); end
    endtask

    task automatic test_branch_jump();
        step();
        n_cmp++; if ({instr_valid, pc_out} !== {1'b1, 32'h10}) begin n_err++; $display("FAIL br_at_0x10: got %h want %h", {instr_valid, pc_out}, {1'b1, 32'h10}); end
        branch_taken = 1'b1; branch_target = 32'h40;
        step();
        branch_taken = 1'b0;
        n_cmp++; if (obs() !== {1'b1, 1'b0, 32'h40}) begin n_err++; $display("FAIL branch_addr: got %h want %h", obs(), {1'b1, 1'b0, 32'h40}); end
        step();
        branch_taken = 1'b1; branch_target = 32'h40; jump_en = 1'b1; jump_target = 32'h80;
        step();
        branch_taken = 1'b0; jump_en = 1'b0;
        n_cmp++; if (obs() !== {1'b1, 1'b0, 32'h80}) begin n_err++; $display("FAIL jump_wins: got %h want %h", obs(), {1'b1, 1'b0, 32'h80}); end
        n_cmp++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL jump_no_misalign: got %b want 0", misalign_err); end
    endtask

    task automatic test_misalign();
        step();
        branch_taken = 1'b1; branch_target = 32'h43;
        step();
        branch_taken = 1'b0;
        n_cmp++; if (obs() !== {1'b1, 1'b0, 32'h40}) begin n_err++; $display("FAIL misalign_addr: got %h want %h", obs(), {1'b1, 1'b0, 32'h40}); end
        n_cmp++; if (misalign_err !== 1'b1) begin n_err++; $display("FAIL misalign_pulse: got %b want 1", misalign_err); end
        step();
        n_cmp++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL misalign_one_cycle: got %b want 0", misalign_err); end
        n_cmp++; if ({instr_valid, pc_out} !== {1'b1, 32'h40}) begin n_err++; $display("FAIL misalign_pc_out: got %h want %h", {instr_valid, pc_out}, {1'b1, 32'h40}); end
        mem_auto = 1'b0; imem_ack = 1'b0;
    endtask

    task automatic test_flush_drop();
        step();
        n_cmp++; if (obs() !== {1'b1, 1'b0, 32'h44}) begin n_err++; $display("FAIL flush_req: got %h want %h", obs(), {1'b1, 1'b0, 32'h44}); end
        flush = 1'b1; flush_pc = 32'h200;
        for (int i = 0; i < 3; i++) begin
            step();
            flush = 1'b0;
            n_cmp++; if (obs() !== {1'b1, 1'b0, 32'h44}) begin n_err++; $display("FAIL flush_hold%0d: got %h want %h", i, obs(), {1'b1, 1'b0, 32'h44}); end
        end
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        n_cmp++; if ({imem_req, instr_valid} !== 2'b00) begin n_err++; $display("FAIL flush_idle: got %b want 00", {imem_req, instr_valid}); end
        imem_ack = 1'b0; mem_auto = 1'b1;
        step();
        n_cmp++; if (obs() !== {1'b1, 1'b0, 32'h200}) begin n_err++; $display("FAIL flush_redirect: got %h want %h", obs(), {1'b1, 1'b0, 32'h200}); end
    endtask

    task automatic test_wrap();
        step();
        n_cmp++; if ({instr_valid, pc_out, instr} !== {1'b1, 32'h200, 32'h200 ^ MEM_KEY}) begin n_err++; $display("FAIL flush_data: got valid=%b pc_out=%h instr=%h want 1 200 %h", instr_valid, pc_out, instr, 32'h200 ^ MEM_KEY); end
        jump_en = 1'b1; jump_target = 32'hFFFF_FFFC;
        step();
        jump_en = 1'b0;
        n_cmp++; if (obs() !== {1'b1, 1'b0, 32'hFFFF_FFFC}) begin n_err++; $display("FAIL wrap_top: got %h want %h", obs(), {1'b1, 1'b0, 32'hFFFF_FFFC}); end
        step();
        n_cmp++; if (pc_plus4 !== 32'h0) begin n_err++; $display("FAIL wrap_pc_plus4: got %h want 0", pc_plus4); end
        step();
        n_cmp++; if ({obs(), misalign_err} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin n_err++; $display("FAIL wrap_addr: got %h want %h", {obs(), misalign_err}, {1'b1, 1'b0, 32'h0, 1'b0}); end
        mem_auto = 1'b0; imem_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        step();
        n_cmp++; if (obs() !== {1'b1, 1'b0, 32'h0}) begin n_err++; $display("FAIL mid_pending: got %h want %h", obs(), {1'b1, 1'b0, 32'h0}); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({obs(), instr, pc_out, pc_plus4, misalign_err} !== {1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h4, 1'b0}) begin
            n_err++; $display("FAIL mid_reset_values: got req=%b valid=%b addr=%h instr=%h pc_out=%h pc_plus4=%h mis=%b want 0 0 0 0 0 4 0", imem_req, instr_valid, imem_addr, instr, pc_out, pc_plus4, misalign_err);
        end
        step();
        imem_ack = 1'b1; imem_rdata = 32'h0BAD_0BAD;
        rst_n = 1'b1;
        step();
        n_cmp++; if (obs() !== {1'b1, 1'b0, 32'h0}) begin n_err++; $display("FAIL stray_ack: got %h want %h", obs(), {1'b1, 1'b0, 32'h0}); end
        imem_rdata = 32'h0 ^ MEM_KEY;
        step();
        n_cmp++; if ({instr_valid, pc_out, instr} !== {1'b1, 32'h0, MEM_KEY}) begin n_err++; $display("FAIL restart: got valid=%b pc_out=%h instr=%h want 1 0 %h", instr_valid, pc_out, instr, MEM_KEY); end
        imem_ack = 1'b0; mem_auto = 1'b1;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch_jump();
        test_misalign();
        test_flush_drop();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
